// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receive front end (start detect, LSB-first shift, parity/stop check)
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    input  logic                  rx_enable,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop_bits2,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] HALF_PT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_PT = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic                  rx_s1;
    logic                  rxs;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_l;
    logic                  par_odd_l;
    logic                  stop2_l;
    logic                  second;
    logic                  p_err;
    logic                  f_err;
    logic                  done;
    logic                  at_pt;

    assign at_pt = cnt == (state == START ? HALF_PT : FULL_PT);

    // two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_s1, rxs} <= 2'b11;
        else {rx_s1, rxs} <= {rx_in, rx_s1};

    // frame FSM; completion is staged through done so outputs update the clk after the last stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            stop2_l    <= 1'b0;
            second     <= 1'b0;
            p_err      <= 1'b0;
            f_err      <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= done;
            if (done) begin
                rx_data    <= shreg;
                parity_err <= p_err;
                frame_err  <= f_err;
                break_det  <= f_err && shreg == '0;
            end
            if (!rx_enable) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
                second  <= 1'b0;
                rx_busy <= 1'b0;
            end else if (baud_tick) begin
                if (state == IDLE) begin
                    if (!rxs) begin
                        state     <= START;
                        cnt       <= '0;
                        rx_busy   <= 1'b1;
                        par_en_l  <= parity_en;
                        par_odd_l <= parity_odd;
                        stop2_l   <= stop_bits2;
                        second    <= 1'b0;
                        p_err     <= 1'b0;
                        f_err     <= 1'b0;
                    end
                end else if (!at_pt) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    case (state)
                        START: begin
                            if (rxs) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == LAST_BIT) state <= par_en_l ? PARITY : STOP;
                        end
                        PARITY: begin
                            p_err <= rxs != (^shreg ^ par_odd_l);
                            state <= STOP;
                        end
                        STOP: begin
                            if (!rxs) f_err <= 1'b1;
                            if (stop2_l && !second) begin
                                second <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: frame-level bench comparing received characters against a bit-timing model
module tb_uart_rx_deserializer;
    localparam int DW = 8;
    localparam int OS = 16;
    localparam int TP = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
        logic          bk;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx_in = 1'b1;
    logic          rx_enable = 1'b0;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          stop_bits2 = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          break_det;
    logic          rx_busy;

    int   errors = 0;
    int   checks = 0;
    rec_t got[$];
    time  got_t[$];
    rec_t exp_q[$];
    time  exp_t[$];
    rec_t last_exp = '0;
    int   dbl_valid = 0;
    int   busy_clks = 0;
    logic prev_valid = 1'b0;

    uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_tick(baud_tick),
        .rx_in(rx_in),
        .rx_enable(rx_enable),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .stop_bits2(stop_bits2),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .break_det(break_det),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            baud_tick = (ph == TP - 1);
            ph = (ph + 1) % TP;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            got.push_back({rx_data, parity_err, frame_err, break_det});
            got_t.push_back($time);
        end
        if (rx_valid && prev_valid) dbl_valid++;
        prev_valid = rx_valid;
        if (rx_busy) busy_clks++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic wait_tick(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic new_test();
        exp_q.delete();
        exp_t.delete();
    endtask

    // serializes one frame from a tick-aligned start and records the expected character and its arrival time
    task automatic send(input logic [DW-1:0] d, input bit pen, input bit podd, input bit s2,
                        input bit pbit, input bit [1:0] stop_low);
        time  t_det;
        int   nst;
        rec_t r;
        nst = s2 ? 2 : 1;
        #1;
        parity_en = pen;
        parity_odd = podd;
        stop_bits2 = s2;
        rx_in = 1'b0;
        wait_tick(1);
        t_det = $time;
        wait_tick(OS - 1);
        for (int i = 0; i < DW; i++) begin
            #1 rx_in = d[i];
            wait_tick(OS);
        end
        if (pen) begin
            #1 rx_in = pbit;
            wait_tick(OS);
        end
        for (int s = 0; s < nst; s++) begin
            if (stop_low[s]) begin
                #1 rx_in = 1'b0;
                wait_tick(OS / 2 + 1);
                #1 rx_in = 1'b1;
                wait_tick(OS / 2 - 1);
            end else begin
                #1 rx_in = 1'b1;
                wait_tick(OS);
            end
        end
        r.d = d;
        r.pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
        r.fe = stop_low[0] || (s2 && stop_low[1]);
        r.bk = (d == '0) && r.fe;
        exp_q.push_back(r);
        exp_t.push_back(t_det + time'(((OS / 2 + OS * (DW + int'(pen) + nst)) * TP + 1) * 10 + 5));
        last_exp = r;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, break_det, rx_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rx_data, rx_valid, parity_err, frame_err, break_det, rx_busy});
        end
        rst_n = 1'b1;
        rx_enable = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({rx_valid, rx_busy} !== 2'b00 || got.size() != 0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b pulses=%0d expected 0 0 0", rx_valid, rx_busy, got.size());
        end
        wait_tick(1);
    endtask

    task automatic test_8n1();
        int base;
        base = got.size();
        new_test();
        send(8'hA5, 0, 0, 0, 0, 2'b00);
        checks++;
        if (got.size() - base != 1) begin
            errors++;
            $display("FAIL 8n1_count: got %0d pulses expected 1", got.size() - base);
        end
        if (got.size() > base) begin
            checks++;
            if (got[base] !== exp_q[0]) begin
                errors++;
                $display("FAIL 8n1_char: got %h expected %h", got[base], exp_q[0]);
            end
            checks++;
            if (got_t[base] !== exp_t[0]) begin
                errors++;
                $display("FAIL 8n1_timing: got %0t expected %0t", got_t[base], exp_t[0]);
            end
        end
    endtask

    task automatic test_parity();
        int base;
        base = got.size();
        new_test();
        send(8'h03, 1, 0, 0, 1, 2'b00);
        send(8'h03, 1, 0, 0, 0, 2'b00);
        send(8'h03, 1, 1, 0, 1, 2'b00);
        checks++;
        if (got.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL parity_count: got %0d pulses expected %0d", got.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL parity_char%0d: got %h expected %h", i, got[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_frame_break();
        int base;
        base = got.size();
        new_test();
        send(8'h00, 0, 0, 0, 0, 2'b01);
        send(8'h55, 0, 0, 0, 0, 2'b00);
        checks++;
        if (got.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL break_count: got %0d pulses expected %0d", got.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL break_char%0d: got %h expected %h", i, got[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_false_start();
        int base;
        int b0;
        base = got.size();
        b0 = busy_clks;
        new_test();
        #1 rx_in = 1'b0;
        wait_tick(4);
        #1 rx_in = 1'b1;
        wait_tick(20);
        checks++;
        if (got.size() != base || busy_clks - b0 != OS / 2 * TP || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch: pulses=%0d busy_clks=%0d busy=%b expected 0 %0d 0", got.size() - base, busy_clks - b0, rx_busy, OS / 2 * TP);
        end
        send(8'h7E, 0, 0, 0, 0, 2'b00);
        checks++;
        if (got.size() - base != 1) begin
            errors++;
            $display("FAIL glitch_recover_count: got %0d pulses expected 1", got.size() - base);
        end
        if (got.size() > base) begin
            checks++;
            if (got[base] !== exp_q[0]) begin
                errors++;
                $display("FAIL glitch_recover_char: got %h expected %h", got[base], exp_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = got.size();
        new_test();
        send(8'h12, 0, 0, 1, 0, 2'b00);
        send(8'h34, 0, 0, 1, 0, 2'b10);
        send(8'h56, 0, 0, 1, 0, 2'b00);
        checks++;
        if (got.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected %0d", got.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_q[i] || got_t[base + i] !== exp_t[i]) begin
                errors++;
                $display("FAIL b2b_char%0d: got %h at %0t expected %h at %0t", i, got[base + i], got_t[base + i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_random();
        int base;
        logic [DW-1:0] d;
        bit pen, podd, s2, pbit;
        bit [1:0] sl;
        base = got.size();
        new_test();
        for (int k = 0; k < 6; k++) begin
            d = DW'($urandom);
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            pbit = 1'($countones(d) % 2) ^ podd ^ ($urandom_range(0, 2) == 0);
            sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send(d, pen, podd, s2, pbit, sl);
        end
        checks++;
        if (got.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d pulses expected %0d", got.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_char%0d: got %h expected %h", i, got[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort_enable();
        int base;
        logic [DW-1:0] d;
        base = got.size();
        d = 8'h3C;
        #1;
        parity_en = 1'b0;
        stop_bits2 = 1'b0;
        rx_in = 1'b0;
        wait_tick(OS);
        for (int i = 0; i < 3; i++) begin
            #1 rx_in = d[i];
            wait_tick(OS);
        end
        #1 rx_in = d[3];
        wait_tick(OS / 2);
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b expected 1", rx_busy);
        end
        rx_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy got %b expected 0", rx_busy);
        end
        rx_in = 1'b1;
        wait_tick(OS * 8);
        @(negedge clk);
        checks++;
        if (got.size() != base || {rx_data, parity_err, frame_err, break_det} !== last_exp) begin
            errors++;
            $display("FAIL abort_outputs: pulses=%0d out=%h expected 0 %h", got.size() - base, {rx_data, parity_err, frame_err, break_det}, last_exp);
        end
        rx_enable = 1'b1;
        wait_tick(1);
    endtask

    task automatic test_reset_mid();
        int base;
        logic [DW-1:0] d;
        d = 8'h99;
        #1;
        parity_en = 1'b0;
        stop_bits2 = 1'b0;
        rx_in = 1'b0;
        wait_tick(OS);
        for (int i = 0; i < 4; i++) begin
            #1 rx_in = d[i];
            wait_tick(OS);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, break_det, rx_busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 0", {rx_data, rx_valid, parity_err, frame_err, break_det, rx_busy});
        end
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(2);
        base = got.size();
        new_test();
        send(8'hC3, 0, 0, 0, 0, 2'b00);
        checks++;
        if (got.size() - base != 1) begin
            errors++;
            $display("FAIL reset_recover_count: got %0d pulses expected 1", got.size() - base);
        end
        if (got.size() > base) begin
            checks++;
            if (got[base] !== exp_q[0]) begin
                errors++;
                $display("FAIL reset_recover_char: got %h expected %h", got[base], exp_q[0]);
            end
        end
    endtask

    task automatic test_no_double();
        checks++;
        if (dbl_valid != 0) begin
            errors++;
            $display("FAIL valid_consecutive: got %0d double pulses expected 0", dbl_valid);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_break();
        test_false_start();
        test_back_to_back();
        test_abort_enable();
        test_random();
        test_reset_mid();
        test_no_double();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel receive front end of the UART RX path. It oversamples the asynchronous `rx_in` line against a 16x baud tick and detects and validates start bits. It shifts in data bits LSB-first, checks optional parity and the stop bit(s), then emits each received character as a one-cycle `rx_valid` pulse carrying `rx_data` and error flags. `rx_valid` and `rx_data` connect directly to the RX FIFO write port (`write_en`, `write_data`).

## Interface
- `DATA_WIDTH`, 8: data bits per character; legal values 5..9.
- `OVERSAMPLE`, 16: baud ticks per bit; even, ≥ 8.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `baud_tick`  in  1  one-clk pulse at OVERSAMPLE × baud rate
- `rx_in`  in  1  asynchronous serial line; idle high
- `rx_enable`  in  1  receiver enable
- `parity_en`  in  1  parity bit present
- `parity_odd`  in  1  1 = odd parity, 0 = even parity
- `stop_bits2`  in  1  1 = two stop bits
- `rx_data`  out  DATA_WIDTH  received character
- `rx_valid`  out  1  one-clk pulse: character complete
- `parity_err`  out  1  parity mismatch on last character
- `frame_err`  out  1  a stop bit sampled low on last character
- `break_det`  out  1  last character all-zero with `frame_err`
- `rx_busy`  out  1  high while state ≠ IDLE

## Operation
- `rx_in` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- `cnt` is the tick counter and `bit_idx` is the data-bit index.
- Sample-point rule: on a `baud_tick`, if `cnt` equals the state's sample point, sample `rxs`, clear `cnt` and act. Otherwise increment `cnt`.
- Sample point is `OVERSAMPLE/2-1` in START and `OVERSAMPLE-1` in DATA, PARITY and STOP.
- With no `baud_tick`, state and counters hold.
- **IDLE:** on a tick with `rx_enable`=1 and `rxs`=0, go to START and set `cnt`=0. This is the detection tick.
  - At the same time, latch `parity_en`, `parity_odd` and `stop_bits2` for the whole frame.
- **START:** at the sample point:
  - `rxs`=0: go to DATA with `bit_idx`=0.
  - `rxs`=1: false start. Return to IDLE with no output.
- **DATA:** at each sample point, shift `rxs` into the shift register at MSB; the LSB arrives first. Increment `bit_idx`.
  - After bit `DATA_WIDTH-1`, go to PARITY if parity is latched on, else STOP.
- **PARITY:** sample the parity bit. The expected value is the XOR of the data bits, XOR'd with `parity_odd`. A mismatch sets the internal parity error; then go to STOP.
- **STOP:** sample the stop bit; a 0 sets the internal frame error.
  - If `stop_bits2` is latched, sample a second stop bit one bit period later.
  - After the final stop sample, return to IDLE immediately (mid-stop-bit) so the next start edge is caught.
- **Completion:** the next clk after the final stop sample:
  - `rx_valid`=1 for exactly one clk.
  - `rx_data`, `parity_err`, `frame_err` and `break_det` update together.
  - `break_det` = (data == 0) & `frame_err`.
  - The character is delivered even with errors set. Flags are per-character and hold until the next completion.
- **Abort:** `rx_enable`=0 in any state returns to IDLE on the next clk, with no `rx_valid` and outputs unchanged.
- No buffering. Back-pressure and overflow are handled downstream.

## Timing
- **Reset values:**
  - outputs: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `rx_busy`=0
  - internal: state IDLE, `cnt`=0, `bit_idx`=0, synchronizer = 1
- Reset asserted mid-frame returns everything to reset values; the partial frame is discarded.
- Input latency: 2 clk synchronizer delay from `rx_in` to `rxs`.
- **Sample ticks, counted from the detection tick (tick 0):**
  - start: tick `OVERSAMPLE/2`
  - data bit i: tick `OVERSAMPLE/2 + OVERSAMPLE·(i+1)`
  - parity: one bit period after the last data bit
  - each stop bit: one bit period after the previous sample
- For 8N1 with `OVERSAMPLE`=16: start at tick 8, bit 0 at tick 24, bit 7 at tick 136, stop at tick 152. `rx_valid` is asserted at clk (tick152 + 1).
- `rx_busy` rises the clk after the detection tick and falls the clk after the final stop sample or abort.
- Back-to-back frames: a start bit immediately following the stop bit is detected with no dead time.
- `rx_valid` never pulses on two consecutive clks.

## Test plan
- 8N1, `rx_in` serializes 0xA5 LSB-first at 16 ticks/bit → one `rx_valid` pulse, `rx_data`=0xA5, all error flags 0, `rx_valid` at tick 152 + 1 clk.
- 8E1 sending 0x03 with parity bit 1 (wrong) → `rx_data`=0x03, `parity_err`=1. Repeat with parity bit 0 → `parity_err`=0. Repeat as 8O1 with parity bit 1 → `parity_err`=0.
- 8N1 sending 0x00 with stop bit held low → `frame_err`=1, `break_det`=1, `rx_data`=0x00. Then a clean 0x55 → all flags clear.
- Low glitch of 4 ticks on idle line → START samples 1, returns to IDLE, no `rx_valid`, `rx_busy` high about 8 ticks. Then 0x7E is received correctly.
- 8N2, back-to-back 0x12, 0x34, 0x56 with no idle gap → three pulses in order with exact values. A second stop bit sampled low on 0x34 → `frame_err`=1 only on that character.
- Abort cases:
  - `rx_enable` dropped during bit 3 → state IDLE next clk, no `rx_valid`.
  - `rst_n` asserted mid-frame → all outputs 0 asynchronously. After release, a fresh 0xC3 is received correctly.
